// File: rtl/count_seq_checker_pkg.sv
// Shared definitions for the arbitrary-sequence counter checker:
// sequence table (6-5-13-2-4-11-9-8), FSM state type and code lookup helpers.
package count_seq_checker_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int SEQ_LEN = 8;

    // SEQ[i] lives at bits [4*i +: 4]; index 0 is code 6, index 7 is code 8.
    localparam logic [31:0] SEQ_TABLE = {4'd8, 4'd9, 4'd11, 4'd4,
                                         4'd2, 4'd13, 4'd5, 4'd6};

    // Code found at a given sequence position.
    function automatic logic [3:0] seq_code(input logic [2:0] i);
        return SEQ_TABLE[{i, 2'b00} +: 4];
    endfunction

    // Code -> {member, pos[2:0]}; non-members return member=0, pos=0.
    function automatic logic [3:0] seq_pos(input logic [3:0] code);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (SEQ_TABLE[4*i +: 4] == code) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/count_seq_checker_seq_decode.sv
// Combinational decoder: 4-bit counter code -> sequence membership and position.
module seq_decode
    import count_seq_checker_pkg::*;
(
    input  logic [3:0] code,
    output logic       member,
    output logic [2:0] pos
);

    logic [3:0] lookup;

    // Table lookup of the incoming code.
    always_comb begin
        lookup = seq_pos(code);
        member = lookup[3];
        pos    = lookup[2:0];
    end

endmodule

// File: rtl/count_seq_checker.sv
// Receive-side monitor for the 6-5-13-2-4-11-9-8 counter. Hunts for a valid
// code, confirms LOCK_N consecutive legal steps, then flags illegal steps.
// Build option: define ERR_STICKY_EN to make err hold until reset instead of
// pulsing once per mismatch.
module count_seq_checker
    import count_seq_checker_pkg::*;
#(
    parameter int LOCK_N = 3,
    parameter int ERR_W  = 8
) (
    input  logic             C,
    input  logic             R,
    input  logic             en,
    input  logic [3:0]       d_in,
    output logic [2:0]       idx,
    output logic             locked,
    output logic             err,
    output logic             wrap,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int GOOD_W = $clog2(LOCK_N + 1);
    localparam logic [GOOD_W-1:0] LOCK_CNT = GOOD_W'(LOCK_N);

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               err_q, err_d;
    logic               wrap_q, wrap_d;
    logic               locked_q, locked_d;

    logic               d_member;
    logic [2:0]         d_pos;
    logic [2:0]         idx_inc;
    logic               match;

    seq_decode u_decode (
        .code   (d_in),
        .member (d_member),
        .pos    (d_pos)
    );

    // The only legal next code is the one after the last accepted one;
    // repeating the current code therefore counts as a mismatch.
    always_comb begin
        idx_inc = idx_q + 3'd1;
        match   = (d_in == seq_code(idx_inc));
    end

    // Next-state logic for the hunt/sync/locked tracker and its outputs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        good_d    = good_q;
        err_cnt_d = err_cnt_q;
        wrap_d    = 1'b0;
`ifdef ERR_STICKY_EN
        err_d     = err_q;
`else
        err_d     = 1'b0;
`endif
        if (en) begin
            case (state_q)
                HUNT: begin
                    if (d_member) begin
                        idx_d   = d_pos;
                        good_d  = '0;
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    if (match) begin
                        idx_d  = idx_inc;
                        good_d = good_q + GOOD_W'(1);
                        if (good_d == LOCK_CNT) begin
                            state_d = LOCKED;
                        end
                    end else if (d_member) begin
                        idx_d  = d_pos;
                        good_d = '0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        idx_d  = idx_inc;
                        wrap_d = (idx_q == 3'd7);
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt_q != {ERR_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                        if (d_member) begin
                            idx_d   = d_pos;
                            good_d  = '0;
                            state_d = SYNC;
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    // State and output registers; reset returns everything to the hunt state.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_q   <= HUNT;
            idx_q     <= '0;
            good_q    <= '0;
            err_cnt_q <= '0;
            err_q     <= 1'b0;
            wrap_q    <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            good_q    <= good_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
            wrap_q    <= wrap_d;
            locked_q  <= locked_d;
        end
    end

    assign idx     = idx_q;
    assign locked  = locked_q;
    assign err     = err_q;
    assign wrap    = wrap_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Self-checking bench for count_seq_checker: directed scenarios plus a
// randomized stream, all compared against a behavioural sequence model.
module tb_count_seq_checker;

    localparam int LOCK_N = 3;
`ifdef ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       C = 1'b0;
    logic       R;
    logic       en;
    logic [3:0] d_in;
    logic [2:0] idx;
    logic       locked;
    logic       err;
    logic       wrap;
    logic [7:0] err_cnt;

    int errors = 0;
    int checks = 0;

    count_seq_checker #(.LOCK_N(LOCK_N), .ERR_W(8)) dut (
        .C       (C),
        .R       (R),
        .en      (en),
        .d_in    (d_in),
        .idx     (idx),
        .locked  (locked),
        .err     (err),
        .wrap    (wrap),
        .err_cnt (err_cnt)
    );

    always #5 C = ~C;

    // ---------------- behavioural model ----------------
    int SEQ [8] = '{6, 5, 13, 2, 4, 11, 9, 8};
    int m_state;   // 0 hunting, 1 synchronising, 2 locked
    int m_idx;
    int m_good;
    int m_cnt;
    bit m_err;
    bit m_wrap;

    function automatic int pos_of(input int x);
        for (int i = 0; i < 8; i++) if (SEQ[i] == x) return i;
        return -1;
    endfunction

    function automatic int next_code();
        return SEQ[(m_idx + 1) % 8];
    endfunction

    task automatic model_reset();
        m_state = 0; m_idx = 0; m_good = 0; m_cnt = 0; m_err = 0; m_wrap = 0;
    endtask

    task automatic model_step(input bit e, input int d);
        int p;
        bit legal;
        m_wrap = 0;
        if (!STICKY) m_err = 0;
        if (!e) return;
        p = pos_of(d);
        legal = (d == next_code());
        if (m_state == 0) begin
            if (p >= 0) begin m_idx = p; m_good = 0; m_state = 1; end
        end else if (m_state == 1) begin
            if (legal) begin
                m_idx = (m_idx + 1) % 8;
                m_good++;
                if (m_good == LOCK_N) m_state = 2;
            end else if (p >= 0) begin
                m_idx = p; m_good = 0;
            end else begin
                m_state = 0;
            end
        end else begin
            if (legal) begin
                if (m_idx == 7) m_wrap = 1;
                m_idx = (m_idx + 1) % 8;
            end else begin
                m_err = 1;
                if (m_cnt < 255) m_cnt++;
                if (p >= 0) begin m_idx = p; m_good = 0; m_state = 1; end
                else m_state = 0;
            end
        end
    endtask

    function automatic logic [14:0] model_vec();
        return {3'(m_idx), (m_state == 2), m_err, m_wrap, 8'(m_cnt)};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit e, input int d);
        @(negedge C);
        en   = e;
        d_in = 4'(d);
        @(posedge C);
        model_step(e, d);
        #1;
        $display("txn en=%0d d_in=%0d -> idx=%0d locked=%0d err=%0d wrap=%0d err_cnt=%0d",
                 e, d, idx, locked, err, wrap, err_cnt);
    endtask

    task automatic do_reset();
        @(negedge C);
        R = 1'b1; en = 1'b0; d_in = 4'd0;
        @(negedge C);
        R = 1'b0;
        model_reset();
    endtask

    // Drive legal codes until the model reports lock (bounded).
    task automatic relock();
        for (int n = 0; n < 12 && m_state != 2; n++) step(1'b1, next_code());
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        R = 1'b1; en = 1'b0; d_in = 4'd0;
        model_reset();
        #2;
        checks++;
        if ({idx, locked, err, wrap, err_cnt} !== 15'd0) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", {idx, locked, err, wrap, err_cnt}, 15'd0);
        end
        @(posedge C); #1;
        checks++;
        if ({idx, locked, err, wrap, err_cnt} !== model_vec()) begin
            errors++;
            $display("FAIL reset_held: got %h want %h", {idx, locked, err, wrap, err_cnt}, model_vec());
        end
        @(negedge C);
        R = 1'b0;
    endtask

    task automatic test_lock();
        int codes [4] = '{6, 5, 13, 2};
        foreach (codes[i]) begin
            step(1'b1, codes[i]);
            checks++;
            if ({idx, locked, err, wrap, err_cnt} !== model_vec()) begin
                errors++;
                $display("FAIL lock_step%0d: got %h want %h", i, {idx, locked, err, wrap, err_cnt}, model_vec());
            end
        end
        checks++;
        if (locked !== 1'b1 || idx !== 3'd3) begin
            errors++;
            $display("FAIL lock_final: got locked=%0d idx=%0d want locked=1 idx=3", locked, idx);
        end
    endtask

    task automatic test_wrap();
        int codes [5] = '{4, 11, 9, 8, 6};
        foreach (codes[i]) begin
            step(1'b1, codes[i]);
            checks++;
            if ({idx, locked, err, wrap, err_cnt} !== model_vec()) begin
                errors++;
                $display("FAIL wrap_step%0d: got %h want %h", i, {idx, locked, err, wrap, err_cnt}, model_vec());
            end
        end
        checks++;
        if (wrap !== 1'b1 || idx !== 3'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_pulse: got wrap=%0d idx=%0d err=%0d want 1 0 0", wrap, idx, err);
        end
        step(1'b1, 5);
        checks++;
        if (wrap !== 1'b0) begin
            errors++;
            $display("FAIL wrap_clear: got wrap=%0d want 0", wrap);
        end
    endtask

    task automatic test_mismatch();
        int codes [3] = '{13, 4, 11};   // reach idx 2, then 4 instead of 2, then continue
        foreach (codes[i]) begin
            step(1'b1, codes[i]);
            checks++;
            if ({idx, locked, err, wrap, err_cnt} !== model_vec()) begin
                errors++;
                $display("FAIL mismatch_step%0d: got %h want %h", i, {idx, locked, err, wrap, err_cnt}, model_vec());
            end
            if (i == 1) begin
                checks++;
                if (err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0 || idx !== 3'd4) begin
                    errors++;
                    $display("FAIL mismatch_flag: got err=%0d cnt=%0d locked=%0d idx=%0d want 1 1 0 4",
                             err, err_cnt, locked, idx);
                end
            end
        end
    endtask

    task automatic test_nonmember();
        int codes [7] = '{9, 8, 7, 9, 8, 6, 5};
        foreach (codes[i]) begin
            step(1'b1, codes[i]);
            checks++;
            if ({idx, locked, err, wrap, err_cnt} !== model_vec()) begin
                errors++;
                $display("FAIL nonmember_step%0d: got %h want %h", i, {idx, locked, err, wrap, err_cnt}, model_vec());
            end
            if (i == 2) begin
                checks++;
                if (err !== 1'b1 || locked !== 1'b0 || err_cnt !== 8'd2) begin
                    errors++;
                    $display("FAIL nonmember_err: got err=%0d locked=%0d cnt=%0d want 1 0 2", err, locked, err_cnt);
                end
            end
            if (i == 5) begin
                checks++;
                if (idx !== 3'd0) begin
                    errors++;
                    $display("FAIL nonmember_resync: got idx=%0d want 0", idx);
                end
            end
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL nonmember_relock: got locked=%0d want 1", locked);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, int'($urandom_range(0, 15)));
            checks++;
            if ({idx, locked, err, wrap, err_cnt} !== model_vec()) begin
                errors++;
                $display("FAIL hold_step%0d: got %h want %h", i, {idx, locked, err, wrap, err_cnt}, model_vec());
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, next_code());
            checks++;
            if ({idx, locked, err, wrap, err_cnt} !== model_vec()) begin
                errors++;
                $display("FAIL resume_step%0d: got %h want %h", i, {idx, locked, err, wrap, err_cnt}, model_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit e;
            int r;
            int d;
            e = ($urandom_range(0, 9) != 0);
            r = int'($urandom_range(0, 9));
            if (r < 7)       d = next_code();
            else if (r == 7) d = SEQ[m_idx];
            else             d = int'($urandom_range(0, 15));
            step(e, d);
            checks++;
            if ({idx, locked, err, wrap, err_cnt} !== model_vec()) begin
                errors++;
                $display("FAIL random_step%0d: got %h want %h", i, {idx, locked, err, wrap, err_cnt}, model_vec());
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 260; i++) begin
            relock();
            step(1'b1, SEQ[m_idx]);
            checks++;
            if ({idx, locked, err, wrap, err_cnt} !== model_vec()) begin
                errors++;
                $display("FAIL saturate_err%0d: got %h want %h", i, {idx, locked, err, wrap, err_cnt}, model_vec());
            end
        end
        checks++;
        if (err_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL saturate_final: got err_cnt=%0d want 255", err_cnt);
        end
    endtask

    task automatic test_sticky();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            relock();
            step(1'b1, SEQ[m_idx]);
            for (int i = 0; i < 2; i++) begin
                step(1'b1, next_code());
                checks++;
                if ({idx, locked, err, wrap, err_cnt} !== model_vec()) begin
                    errors++;
                    $display("FAIL sticky_after%0d_%0d: got %h want %h", k, i,
                             {idx, locked, err, wrap, err_cnt}, model_vec());
                end
            end
        end
        checks++;
        if (err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL sticky_count: got err_cnt=%0d want 2", err_cnt);
        end
        @(negedge C);
        en = 1'b1;
        d_in = 4'(next_code());
        #2;
        R = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({idx, locked, err, wrap, err_cnt} !== 15'd0) begin
            errors++;
            $display("FAIL midreset_async: got %h want %h", {idx, locked, err, wrap, err_cnt}, 15'd0);
        end
        @(posedge C); #1;
        checks++;
        if ({idx, locked, err, wrap, err_cnt} !== model_vec()) begin
            errors++;
            $display("FAIL midreset_held: got %h want %h", {idx, locked, err, wrap, err_cnt}, model_vec());
        end
        @(negedge C);
        R = 1'b0;
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_wrap();
        test_mismatch();
        test_nonmember();
        test_hold();
        test_random();
        test_saturate();
        test_sticky();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
